// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM state, width helpers and default bias for the sequential FIR
package fir_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    localparam int DEF_BIAS = 34406;

    function automatic int ptr_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    function automatic int acc_w(input int dw, input int cw, input int n);
        return dw + cw + $clog2(n) + 1;
    endfunction

    // Post-bias width: wide enough for the accumulator, a 32-bit bias and one
    // more bit than the output so saturation bounds always fit.
    function automatic int sum_w(input int aw, input int ow);
        int m;
        m = aw > 32 ? aw : 32;
        m = m > ow ? m : ow;
        return m + 1;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// fir_mac_unit: registered signed multiply-accumulate with clear and enable
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : zero the accumulator (wins over en)
//   en           : acc <= acc + a*b
//   a, b         : signed operands
//   acc          : signed accumulator
module fir_mac_unit #(
    parameter int A_W   = 12,
    parameter int B_W   = 12,
    parameter int ACC_W = 31
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [A_W+B_W-1:0] prod;

    assign prod = a * b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + ACC_W'(prod);
    end

endmodule

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed FIR, y = sum x[n-k]*coef[k] + BIAS, one MAC over N_TAPS cycles
//   clk, reset_n                      : clock, asynchronous active-low reset
//   in_valid/in_data/in_ready         : sample input handshake
//   coef_we/coef_addr/coef_wdata      : coefficient write port (honoured in IDLE only)
//   flush                             : synchronous clear of sample history, keeps coefficients
//   out_valid/out_data/out_ready      : result output handshake
//   Define FIR_SAT_EN to saturate the result to OUT_W bits; otherwise it wraps.
module fir_mac_seq
    import fir_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int COEF_W = 12,
    parameter int N_TAPS = 36,
    parameter int OUT_W  = 24,
    parameter int SHIFT  = 0,
    parameter int BIAS   = DEF_BIAS
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            in_valid,
    input  logic signed [DATA_W-1:0]        in_data,
    output logic                            in_ready,
    input  logic                            coef_we,
    input  logic [ptr_w(N_TAPS)-1:0]        coef_addr,
    input  logic signed [COEF_W-1:0]        coef_wdata,
    input  logic                            flush,
    output logic                            out_valid,
    output logic signed [OUT_W-1:0]         out_data,
    input  logic                            out_ready
);

    localparam int PTR_W = ptr_w(N_TAPS);
    localparam int ACC_W = acc_w(DATA_W, COEF_W, N_TAPS);
    localparam int SUM_W = sum_w(ACC_W, OUT_W);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(N_TAPS - 1);
    localparam logic [PTR_W:0]   FULL = (PTR_W + 1)'(N_TAPS);

    logic signed [DATA_W-1:0] smp  [N_TAPS];
    logic signed [COEF_W-1:0] coef [N_TAPS];
    state_t                   state;
    logic [PTR_W-1:0]         wr_ptr, newest, k, rd_idx;
    logic [PTR_W:0]           fill_cnt, fill_nxt;
    logic                     accept, mac_clr, mac_en;
    logic signed [ACC_W-1:0]  acc;
    logic signed [SUM_W-1:0]  sum, shifted;
    logic signed [OUT_W-1:0]  reduced;

    assign accept   = in_valid && in_ready && state == IDLE;
    assign fill_nxt = fill_cnt == FULL ? FULL : fill_cnt + 1'b1;
    assign mac_clr  = flush || (accept && fill_nxt == FULL);
    assign mac_en   = state == ACCUM && !flush;

    // Tap k reads the sample k steps older than the newest, wrapping around the ring.
    assign rd_idx = newest >= k ? newest - k : PTR_W'(FULL + newest - k);

    fir_mac_unit #(
        .A_W   (DATA_W),
        .B_W   (COEF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (mac_clr),
        .en      (mac_en),
        .a       (smp[rd_idx]),
        .b       (coef[k]),
        .acc     (acc)
    );

    assign sum     = SUM_W'(acc) + SUM_W'(BIAS);
    assign shifted = sum >>> SHIFT;

`ifdef FIR_SAT_EN
    localparam logic signed [SUM_W-1:0] MAXV = SUM_W'({(OUT_W - 1){1'b1}});
    localparam logic signed [SUM_W-1:0] MINV = ~MAXV;
    always_comb reduced = shifted > MAXV ? MAXV[OUT_W-1:0] :
                          shifted < MINV ? MINV[OUT_W-1:0] : OUT_W'(shifted);
`else
    always_comb reduced = OUT_W'(shifted);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            for (int i = 0; i < N_TAPS; i++) smp[i] <= '0;
        else if (flush)
            for (int i = 0; i < N_TAPS; i++) smp[i] <= '0;
        else if (accept)
            smp[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            for (int i = 0; i < N_TAPS; i++) coef[i] <= '0;
        else if (coef_we && state == IDLE && !flush)
            coef[coef_addr] <= coef_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            newest    <= '0;
            fill_cnt  <= '0;
            k         <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            k         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        newest   <= wr_ptr;
                        wr_ptr   <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
                        fill_cnt <= fill_nxt;
                        if (fill_nxt == FULL) begin
                            state    <= ACCUM;
                            k        <= '0;
                            in_ready <= 1'b0;
                        end
                    end
                end
                ACCUM: begin
                    k <= k + 1'b1;
                    if (k == LAST) state <= OUT;
                end
                OUT: begin
                    // First OUT cycle latches the finished accumulator.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= reduced;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
// tb_fir_mac_seq: randomized self-checking bench for fir_mac_seq against a sliding-window model
module tb_fir_mac_seq;

    localparam int N     = 36;
    localparam int OW    = 24;
    localparam int BIAS  = 34406;
    localparam int SHIFT = 0;

    logic              clk;
    logic              reset_n;
    logic              in_valid;
    logic [11:0]       in_data;
    logic              in_ready;
    logic              coef_we;
    logic [5:0]        coef_addr;
    logic [11:0]       coef_wdata;
    logic              flush;
    logic              out_valid;
    logic [OW-1:0]     out_data;
    logic              out_ready;

    int checks = 0;
    int errors = 0;
    int coefs [N];
    int win [$];

    fir_mac_seq #(
        .DATA_W (12),
        .COEF_W (12),
        .N_TAPS (N),
        .OUT_W  (OW),
        .SHIFT  (SHIFT),
        .BIAS   (BIAS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int sext12(input int v);
        int u;
        u = v & 32'hFFF;
        return u >= 2048 ? u - 4096 : u;
    endfunction

    // y = sum_k x[n-k]*coef[k] + BIAS, then shift and reduce to OW bits
    function automatic logic [OW-1:0] model_out();
        longint s;
        logic [63:0] r;
        s = 0;
        for (int i = 0; i < N; i++) s += longint'(win[i]) * longint'(coefs[i]);
        s = (s + BIAS) >>> SHIFT;
`ifdef FIR_SAT_EN
        if (s > (64'sd1 <<< (OW - 1)) - 1) s = (64'sd1 <<< (OW - 1)) - 1;
        if (s < -(64'sd1 <<< (OW - 1))) s = -(64'sd1 <<< (OW - 1));
`endif
        r = 64'(s);
        return r[OW-1:0];
    endfunction

    task automatic write_coef(input int a, input int v);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 6'(a); coef_wdata = 12'(v);
        @(posedge clk);
        #1 coef_we = 1'b0;
        coefs[a] = sext12(v);
    endtask

    task automatic model_reset();
        win.delete();
        for (int i = 0; i < N; i++) coefs[i] = 0;
    endtask

    // mode 0 normal, 1 hold out_ready low in OUT, 2 flush in OUT, 3 reset mid-ACCUM
    task automatic send(input string tag, input int d, input int mode, output logic [OW-1:0] got);
        int t;
        logic [OW-1:0] exp;
        got = '0;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        if (!in_ready) begin
            check({tag, "_rdy_timeout"}, 0, 1);
            return;
        end
        in_valid = 1'b1; in_data = 12'(d);
        @(posedge clk);
        #1 in_valid = 1'b0;
        win.push_front(sext12(d));
        if (win.size() > N) void'(win.pop_back());
        if (win.size() < N) return;
        if (mode == 3) begin
            repeat (5) @(posedge clk);
            #1 reset_n = 1'b0;
            #1;
            check({tag, "_rst_valid"}, out_valid, 0);
            check({tag, "_rst_data"}, out_data, 0);
            check({tag, "_rst_ready"}, in_ready, 0);
            model_reset();
            repeat (2) @(negedge clk);
            reset_n = 1'b1;
            return;
        end
        exp = model_out();
        t = 0;
        while (!out_valid && t < 200) begin @(posedge clk); #1; t++; end
        check({tag, "_latency"}, t, N + 1);
        check({tag, "_data"}, out_data, exp);
        got = out_data;
        if (mode == 1) begin
            for (int i = 0; i < 10; i++) begin
                coef_we = 1'b1; coef_addr = 6'(i); coef_wdata = 12'h7AB;
                @(posedge clk);
                #1;
                check({tag, "_hold_valid"}, out_valid, 1);
                check({tag, "_hold_data"}, out_data, exp);
                check({tag, "_hold_ready"}, in_ready, 0);
            end
            coef_we = 1'b0;
        end
        if (mode == 2) begin
            flush = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
            check({tag, "_flush_valid"}, out_valid, 0);
            check({tag, "_flush_ready"}, in_ready, 1);
            win.delete();
            return;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_drop"}, out_valid, 0);
        check({tag, "_ready_after"}, in_ready, 1);
    endtask

    task automatic idle_no_output(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        logic [OW-1:0] got;
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; coef_we = 1'b0;
        coef_addr = '0; coef_wdata = '0; flush = 1'b0; out_ready = 1'b0;
        model_reset();
        #3;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1 check("release_in_ready", in_ready, 1);

        // unity coefficients, constant samples, long warm-up gap
        for (int i = 0; i < N; i++) write_coef(i, 12'h001);
        for (int i = 0; i < N - 1; i++) send("warm", 12'h010, 0, got);
        idle_no_output("warm_no_valid", 100);
        send("unity", 12'h010, 0, got);
        check("unity_const", got, 34982);

        // only tap 0 nonzero: output follows the newest sample
        write_coef(0, 12'hFFF);
        for (int i = 1; i < N; i++) write_coef(i, 0);
        send("tap0_a", 12'h800, 0, got);
        check("tap0_a_const", got, 36454);
        send("tap0_b", 12'h005, 0, got);
        check("tap0_b_const", got, 34401);

        // random coefficients and samples
        for (int i = 0; i < N; i++) write_coef(i, int'($urandom_range(0, 4095)));
        for (int j = 0; j < 12; j++) send("rand", int'($urandom_range(0, 4095)), 0, got);

        // back-pressure with ignored coefficient writes, then confirm they were ignored
        send("hold", int'($urandom_range(0, 4095)), 1, got);
        send("after_hold", int'($urandom_range(0, 4095)), 0, got);

        // flush in OUT keeps coefficients and empties the window
        send("flush", int'($urandom_range(0, 4095)), 2, got);
        for (int j = 0; j < N - 1; j++) send("refill", int'($urandom_range(0, 4095)), 0, got);
        idle_no_output("refill_no_valid", 20);
        send("post_flush", int'($urandom_range(0, 4095)), 0, got);

        // reset mid-ACCUM clears coefficients and history
        send("rst_accum", int'($urandom_range(0, 4095)), 3, got);
        @(posedge clk);
        #1 check("rst_release_ready", in_ready, 1);
        for (int i = 0; i < N; i++) write_coef(i, 12'h7FF);
        for (int j = 0; j < N - 1; j++) send("sat_warm", 12'h7FF, 0, got);
        idle_no_output("sat_no_valid", 50);
        send("sat", 12'h7FF, 0, got);
`ifdef FIR_SAT_EN
        check("sat_const", got, 24'h7FFFFF);
`else
        check("sat_const", got, 24'hFE468A);
`endif
        for (int j = 0; j < 6; j++) send("rand2", int'($urandom_range(0, 4095)), 0, got);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
